uart_transmitter: RTL and testbench

Buffered 8N1 UART transmitter: accepts bytes over a valid/ready handshake into an internal FIFO and serializes them onto the `tx` line at a fixed baud rate. It is the PC-bound counterpart of the design's UART receive path and returns processed series data to the host. Frames are sent back-to-back with no idle gap while the FIFO holds data.

---
 rtl/uart_transmitter.sv | 167 ++++++++++++++++
 tb/tb_uart_transmitter.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter.sv
// Buffered 8N1 UART transmitter.
// Bytes arrive over a valid/ready handshake into a small FIFO. An FSM then
// serializes them onto tx: a start bit, eight data bits LSB first, and one
// stop bit. While the FIFO still holds data, frames follow each other with
// no idle gap between them.
//
// Handshake: a byte is taken at any rising edge where data_in_valid and
// data_in_ready are both high. data_in_ready depends only on the registered
// fifo_count. data_in is ignored on edges where no transfer happens.
module uart_transmitter #(
    parameter int CLOCK_FREQ = 50000000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [7:0]                    data_in,
    input  logic                          data_in_valid,
    output logic                          data_in_ready,
    output logic                          tx,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int PTR_W        = $clog2(FIFO_DEPTH);
    localparam int COUNT_W      = PTR_W + 1;
    localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

    // The bit counter is 16 bits wide. The FIFO pointers wrap naturally, which
    // only works when the depth is a power of two.
    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_rate
        $error("uart_transmitter: CLOCK_FREQ / BAUD_RATE must be in 2..65535");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_transmitter: FIFO_DEPTH must be a power of two >= 2");
    end

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START_BIT = 2'd1,
        DATA_BITS = 2'd2,
        STOP_BIT  = 2'd3
    } state_t;

    state_t          state;
    logic [15:0]     bit_count;
    logic [2:0]      bit_index;
    logic [2:0]      next_index;
    logic [7:0]      shift;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic            push;
    logic            pop;
    logic            bit_done;

    assign data_in_ready = (fifo_count != COUNT_W'(FIFO_DEPTH));
    assign push          = data_in_valid && data_in_ready;
    assign bit_done      = (bit_count == BIT_LAST);
    assign next_index    = bit_index + 3'd1;
    // The head is taken either from idle, or on the final stop-bit cycle so
    // that the next start bit follows immediately.
    assign pop = (fifo_count != '0) &&
                 ((state == IDLE) || ((state == STOP_BIT) && bit_done));

    // FIFO storage: written on an accepted push. It needs no reset because
    // fifo_count tells us which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // FIFO pointers and occupancy. A push and a pop on the same edge leave the
    // count unchanged.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Frame FSM. tx is driven on each transition so that the line holds the
    // value of the bit that was just entered for its full bit time.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            bit_count <= '0;
            bit_index <= '0;
            shift     <= '0;
            tx        <= 1'b1;
            tx_busy   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        shift     <= mem[rd_ptr];
                        bit_count <= '0;
                        state     <= START_BIT;
                        tx        <= 1'b0;
                        tx_busy   <= 1'b1;
                    end
                end
                START_BIT: begin
                    if (bit_done) begin
                        bit_count <= '0;
                        bit_index <= '0;
                        state     <= DATA_BITS;
                        tx        <= shift[0];
                    end else begin
                        bit_count <= bit_count + 16'd1;
                    end
                end
                DATA_BITS: begin
                    if (bit_done) begin
                        bit_count <= '0;
                        if (bit_index == 3'd7) begin
                            state <= STOP_BIT;
                            tx    <= 1'b1;
                        end else begin
                            bit_index <= next_index;
                            tx        <= shift[next_index];
                        end
                    end else begin
                        bit_count <= bit_count + 16'd1;
                    end
                end
                STOP_BIT: begin
                    if (bit_done) begin
                        bit_count <= '0;
                        if (pop) begin
                            shift <= mem[rd_ptr];
                            state <= START_BIT;
                            tx    <= 1'b0;
                        end else begin
                            state   <= IDLE;
                            tx_busy <= 1'b0;
                        end
                    end else begin
                        bit_count <= bit_count + 16'd1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    tx      <= 1'b1;
                    tx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Testbench for uart_transmitter. It runs with a 10-cycle bit time and a
// 4-entry FIFO.
//
// The reference model works from the line protocol, not from the RTL. Each
// accepted byte owns a 10-bit window on tx. A window starts one edge after
// the byte is accepted, or at the end of the previous window if that is
// later. A byte is accepted at the first offered edge where the buffered
// count is below the depth. The buffered count is the number of bytes
// accepted minus the number of windows already started.
//
// Samples are indexed by the edge that produced them: sample p is taken on
// the falling edge after rising edge p, and p = 0 is the edge that accepts
// the first byte of a stream.
module tb_uart_transmitter;

    localparam int CLOCK_FREQ = 1000;
    localparam int BAUD_RATE  = 100;
    localparam int FIFO_DEPTH = 4;
    localparam int C          = CLOCK_FREQ / BAUD_RATE;
    localparam int FRAME      = 10 * C;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       data_in_valid = 1'b0;
    logic       data_in_ready;
    logic       tx;
    logic       tx_busy;
    logic [2:0] fifo_count;

    uart_transmitter #(
        .CLOCK_FREQ(CLOCK_FREQ),
        .BAUD_RATE (BAUD_RATE),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .data_in      (data_in),
        .data_in_valid(data_in_valid),
        .data_in_ready(data_in_ready),
        .tx           (tx),
        .tx_busy      (tx_busy),
        .fifo_count   (fifo_count)
    );

    // Clock generation
    always #5 clk = ~clk;

    int         vectors = 0;
    int         miscompares = 0;

    logic       tx_log[$];
    logic       busy_log[$];
    bit         logging = 1'b0;
    logic [7:0] stim_bytes[$];
    int         stim_gap[$];
    int         act_acc[$];
    int         exp_acc[$];
    int         exp_start[$];

    int         max_count = 0;
    int         ready_bad = 0;

    logic [7:0] rx_q[$];
    int         framing_errors = 0;
    bit         rx_en = 1'b0;
    logic       tx_prev = 1'b1;
    logic [7:0] rx_byte;
    logic       rx_start;
    logic       rx_stop;

    // Line log: one sample of tx and tx_busy per cycle, taken away from the active edge
    always @(negedge clk) begin
        if (logging) begin
            tx_log.push_back(tx);
            busy_log.push_back(tx_busy);
        end
    end

    // Occupancy monitor: peak count, and whether ready tracks the count
    always @(negedge clk) begin
        if (reset_n) begin
            if (int'(fifo_count) > max_count) max_count = int'(fifo_count);
            if (data_in_ready !== (fifo_count != 3'(FIFO_DEPTH))) ready_bad++;
        end
    end

    // Behavioural UART receiver: sample each bit at its midpoint
    always begin
        @(negedge clk);
        if (rx_en && tx_prev === 1'b1 && tx === 1'b0) begin
            repeat (C / 2) @(negedge clk);
            rx_start = tx;
            for (int i = 0; i < 8; i++) begin
                repeat (C) @(negedge clk);
                rx_byte[i] = tx;
            end
            repeat (C) @(negedge clk);
            rx_stop = tx;
            if (rx_start !== 1'b0 || rx_stop !== 1'b1) framing_errors++;
            rx_q.push_back(rx_byte);
        end
        tx_prev = tx;
    end

    // Reference model: acceptance edge and window start for every byte
    task automatic compute_model();
        int p, cnt, s, prev_end;
        exp_acc.delete();
        exp_start.delete();
        prev_end = 0;
        for (int k = 0; k < stim_bytes.size(); k++) begin
            p = (k == 0) ? 0 : exp_acc[k-1] + 1 + stim_gap[k];
            cnt = FIFO_DEPTH;
            while (cnt >= FIFO_DEPTH) begin
                cnt = k;
                for (int j = 0; j < k; j++) if (exp_start[j] < p) cnt--;
                if (cnt >= FIFO_DEPTH) p++;
            end
            exp_acc.push_back(p);
            s = (p + 1 > prev_end) ? p + 1 : prev_end;
            exp_start.push_back(s);
            prev_end = s + FRAME;
        end
    endtask

    // Expected line level and busy flag at sample i; owner is the byte's window (n = idle)
    function automatic void exp_at(input int i, output logic etx, output logic ebusy,
                                   output int owner);
        logic [7:0] v;
        int b;
        etx = 1'b1;
        ebusy = 1'b0;
        owner = stim_bytes.size();
        for (int k = 0; k < stim_bytes.size(); k++) begin
            if (i >= exp_start[k] && i < exp_start[k] + FRAME) begin
                v = stim_bytes[k];
                b = (i - exp_start[k]) / C;
                ebusy = 1'b1;
                owner = k;
                etx = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : v[b-1];
            end
        end
    endfunction

    // Driver: offer stim_bytes with stim_gap idle cycles before each; optionally wait for the line to drain
    task automatic run_stream(input bit wait_done);
        int waited, total;
        logging = 1'b0;
        tx_log.delete();
        busy_log.delete();
        act_acc.delete();
        @(negedge clk);
        for (int k = 0; k < stim_bytes.size(); k++) begin
            data_in = stim_bytes[k];
            data_in_valid = 1'b1;
            waited = 0;
            while (!data_in_ready) begin
                @(negedge clk);
                waited++;
                if (waited > 50 * FRAME) begin
                    miscompares++;
                    $display("FAIL push_timeout: byte %0d not accepted in %0d cycles, need acceptance", k, waited);
                    $fatal(1, "push never accepted");
                end
            end
            @(posedge clk);
            logging = 1'b1;
            act_acc.push_back(tx_log.size());
            @(negedge clk);
            data_in_valid = 1'b0;
            data_in = 8'($urandom);
            if (k + 1 < stim_bytes.size()) repeat (stim_gap[k+1]) @(negedge clk);
        end
        if (wait_done) begin
            compute_model();
            total = exp_start[stim_bytes.size()-1] + FRAME + 20;
            waited = 0;
            while (tx_log.size() < total && waited < total + 1000) begin
                @(negedge clk);
                waited++;
            end
            logging = 1'b0;
        end
    endtask

    // Compare the logged stream against the model: acceptance edges, every window, idle time, busy total
    task automatic test_stream_waveform(input string name);
        int n, total, owner, busy_ones;
        int first_bad[$];
        logic etx, ebusy;
        n = stim_bytes.size();
        total = exp_start[n-1] + FRAME + 20;
        vectors++;
        if (tx_log.size() < total) begin
            miscompares++;
            $display("FAIL %s log_length: got %0d samples, need %0d", name, tx_log.size(), total);
        end
        for (int k = 0; k < n; k++) begin
            vectors++;
            if (act_acc.size() <= k || act_acc[k] != exp_acc[k]) begin
                miscompares++;
                $display("FAIL %s accept_edge[%0d]: got %0d, expected %0d", name, k,
                         (act_acc.size() > k) ? act_acc[k] : -1, exp_acc[k]);
            end
        end
        for (int k = 0; k <= n; k++) first_bad.push_back(-1);
        busy_ones = 0;
        for (int i = 0; i < total && i < tx_log.size(); i++) begin
            exp_at(i, etx, ebusy, owner);
            if (busy_log[i] === 1'b1) busy_ones++;
            if ((tx_log[i] !== etx || busy_log[i] !== ebusy) && first_bad[owner] == -1)
                first_bad[owner] = i;
        end
        for (int k = 0; k <= n; k++) begin
            vectors++;
            if (first_bad[k] != -1) begin
                exp_at(first_bad[k], etx, ebusy, owner);
                miscompares++;
                $display("FAIL %s %s%0d: sample %0d tx=%b busy=%b, expected tx=%b busy=%b", name,
                         (k == n) ? "idle" : "frame", k, first_bad[k], tx_log[first_bad[k]],
                         busy_log[first_bad[k]], etx, ebusy);
            end
        end
        vectors++;
        if (busy_ones != n * FRAME) begin
            miscompares++;
            $display("FAIL %s busy_cycles: got %0d, expected %0d", name, busy_ones, n * FRAME);
        end
    endtask

    task automatic test_reset();
        int bad;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (tx !== 1'b1) begin miscompares++; $display("FAIL reset_tx: got %b, expected 1", tx); end
        vectors++;
        if (tx_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b, expected 0", tx_busy); end
        vectors++;
        if (data_in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b, expected 1", data_in_ready); end
        vectors++;
        if (fifo_count !== 3'd0) begin miscompares++; $display("FAIL reset_count: got %0d, expected 0", fifo_count); end
        reset_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || tx_busy !== 1'b0 || data_in_ready !== 1'b1 || fifo_count !== 3'd0) bad++;
        end
        vectors++;
        if (bad != 0) begin miscompares++; $display("FAIL reset_quiet: %0d bad cycles after release, expected 0", bad); end
    endtask

    task automatic test_single_byte();
        logic a5_bits[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        int idx;
        stim_bytes = '{8'hA5};
        stim_gap = '{0};
        run_stream(1'b1);
        test_stream_waveform("single");
        vectors++;
        if (tx_log.size() < 2 || tx_log[0] !== 1'b1 || tx_log[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL single_fall: tx at samples 0,1 = %b,%b, expected 1,0",
                     (tx_log.size() > 0) ? tx_log[0] : 1'bx, (tx_log.size() > 1) ? tx_log[1] : 1'bx);
        end
        for (int j = 0; j < 10; j++) begin
            idx = 1 + j * C + C / 2;
            vectors++;
            if (tx_log.size() <= idx || tx_log[idx] !== a5_bits[j]) begin
                miscompares++;
                $display("FAIL single_bit%0d: got %b, expected %b", j,
                         (tx_log.size() > idx) ? tx_log[idx] : 1'bx, a5_bits[j]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int first, last, ones;
        stim_bytes = '{8'h00, 8'hFF, 8'h55};
        stim_gap = '{0, 0, 0};
        run_stream(1'b1);
        test_stream_waveform("b2b");
        first = -1;
        last = -1;
        ones = 0;
        for (int i = 0; i < busy_log.size(); i++) begin
            if (busy_log[i] === 1'b1) begin
                if (first == -1) first = i;
                last = i;
                ones++;
            end
        end
        vectors++;
        if (first != 1 || last - first + 1 != 3 * FRAME || ones != 3 * FRAME) begin
            miscompares++;
            $display("FAIL b2b_busy_run: first %0d span %0d ones %0d, expected 1 300 300",
                     first, last - first + 1, ones);
        end
    endtask

    task automatic test_backpressure();
        stim_bytes.delete();
        stim_gap.delete();
        for (int k = 0; k < 8; k++) begin
            stim_bytes.push_back(8'(k + 1));
            stim_gap.push_back(0);
        end
        max_count = 0;
        ready_bad = 0;
        run_stream(1'b1);
        test_stream_waveform("backpressure");
        for (int k = 0; k < 5; k++) begin
            vectors++;
            if (act_acc[k] != k) begin
                miscompares++;
                $display("FAIL bp_early_accept[%0d]: got edge %0d, expected %0d", k, act_acc[k], k);
            end
        end
        vectors++;
        if (act_acc[5] != 1 + FRAME + 1) begin
            miscompares++;
            $display("FAIL bp_sixth_accept: got edge %0d, expected %0d", act_acc[5], 1 + FRAME + 1);
        end
        vectors++;
        if (max_count != FIFO_DEPTH) begin
            miscompares++;
            $display("FAIL bp_max_count: got %0d, expected %0d", max_count, FIFO_DEPTH);
        end
        vectors++;
        if (ready_bad != 0) begin
            miscompares++;
            $display("FAIL bp_ready_vs_count: %0d bad cycles, expected 0", ready_bad);
        end
    endtask

    task automatic test_random();
        stim_bytes.delete();
        stim_gap.delete();
        for (int k = 0; k < 30; k++) begin
            stim_bytes.push_back(8'($urandom));
            stim_gap.push_back(($urandom_range(0, 3) == 0) ? $urandom_range(0, 150) : $urandom_range(0, 3));
        end
        max_count = 0;
        run_stream(1'b1);
        test_stream_waveform("random");
        vectors++;
        if (max_count > FIFO_DEPTH) begin
            miscompares++;
            $display("FAIL random_max_count: got %0d, limit %0d", max_count, FIFO_DEPTH);
        end
    endtask

    task automatic test_reset_mid_frame();
        int bad, waited;
        stim_bytes = '{8'h3C, 8'hAA, 8'h55};
        stim_gap = '{0, 0, 0};
        run_stream(1'b0);
        // Start bit is sample 1, so data bit 3 covers samples 1+4C .. 1+5C-1
        waited = 0;
        while (tx_log.size() < 1 + 4 * C + C / 2 && waited < 10 * FRAME) begin
            @(negedge clk);
            waited++;
        end
        logging = 1'b0;
        vectors++;
        if (fifo_count !== 3'd2) begin
            miscompares++;
            $display("FAIL midreset_queued: got %0d, expected 2", fifo_count);
        end
        #1 reset_n = 1'b0;
        #1;
        vectors++;
        if (tx !== 1'b1 || tx_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_async: tx=%b busy=%b, expected tx=1 busy=0", tx, tx_busy);
        end
        vectors++;
        if (fifo_count !== 3'd0) begin
            miscompares++;
            $display("FAIL midreset_count: got %0d, expected 0", fifo_count);
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 5 * FRAME; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || tx_busy !== 1'b0 || fifo_count !== 3'd0) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL midreset_no_resume: %0d active cycles after release, expected 0", bad);
        end
    endtask

    task automatic test_loopback();
        int bad_idx;
        rx_q.delete();
        framing_errors = 0;
        rx_en = 1'b1;
        stim_bytes.delete();
        stim_gap.delete();
        for (int k = 0; k < 256; k++) begin
            stim_bytes.push_back(8'(k));
            stim_gap.push_back($urandom_range(0, 2));
        end
        run_stream(1'b1);
        rx_en = 1'b0;
        test_stream_waveform("loopback");
        vectors++;
        if (rx_q.size() != 256) begin
            miscompares++;
            $display("FAIL loop_count: received %0d bytes, expected 256", rx_q.size());
        end
        bad_idx = -1;
        for (int k = 0; k < 256 && k < rx_q.size(); k++) begin
            if (rx_q[k] !== 8'(k) && bad_idx == -1) bad_idx = k;
        end
        vectors++;
        if (bad_idx != -1) begin
            miscompares++;
            $display("FAIL loop_data: byte %0d got %02h, expected %02h", bad_idx, rx_q[bad_idx], 8'(bad_idx));
        end
        vectors++;
        if (framing_errors != 0) begin
            miscompares++;
            $display("FAIL loop_framing: got %0d framing errors, expected 0", framing_errors);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_mid_frame();
        test_loopback();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
